// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle produced by vga_sync_gen.
//   x, y        : current pixel column / line
//   hsync_n     : horizontal sync, active-low
//   vsync_n     : vertical sync, active-low
//   video_on    : high while (x,y) lies in the visible area
//   p_tick      : pixel-enable strobe (one system clock per pixel)
//   frame_start : one-clock pulse at pixel (0,0) while p_tick is high
// master = timing generator, slave = consumer (indicator logic, bench).
interface vga_sync_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync_n;
  logic       vsync_n;
  logic       video_on;
  logic       p_tick;
  logic       frame_start;

  modport master (
    output x, y, hsync_n, vsync_n, video_on, p_tick, frame_start
  );

  modport slave (
    input x, y, hsync_n, vsync_n, video_on, p_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
//   clk   : system clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   vga   : vga_sync_gen_if master (x, y, syncs, video_on, p_tick, frame_start)
// A divider produces one pixel-enable every CLK_DIV clocks; the x/y raster
// counters advance on that enable. Sync and blanking flags are registered
// from the next-state x/y so they line up with the x/y presented in the
// same cycle without any decode glitches.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_sync_gen_if.master  vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  // A one-bit divider is kept for CLK_DIV=1; it simply stays at zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic [9:0]       x_r;
  logic [9:0]       y_r;
  logic [9:0]       x_next_s;
  logic [9:0]       y_next_s;
  logic             hsync_n_r;
  logic             vsync_n_r;
  logic             video_on_r;
  logic             tick_s;

  // Horizontal sync window decode.
  function automatic logic in_hsync(input logic [9:0] xv);
    in_hsync = (xv >= 10'(H_VIS + H_FP)) && (xv <= 10'(H_VIS + H_FP + H_SYNC - 1));
  endfunction

  // Vertical sync window decode.
  function automatic logic in_vsync(input logic [9:0] yv);
    in_vsync = (yv >= 10'(V_VIS + V_FP)) && (yv <= 10'(V_VIS + V_FP + V_SYNC - 1));
  endfunction

  // Visible-area decode.
  function automatic logic in_visible(input logic [9:0] xv, input logic [9:0] yv);
    in_visible = (xv < 10'(H_VIS)) && (yv < 10'(V_VIS));
  endfunction

  assign tick_s = (div_r == DIV_W'(CLK_DIV - 1));

  // Next-state divider and raster counters.
  always_comb begin
    div_next_s = div_r;
    x_next_s   = x_r;
    y_next_s   = y_r;
    if (tick_s) begin
      div_next_s = {DIV_W{1'b0}};
      if (x_r == 10'(H_TOT - 1)) begin
        x_next_s = 10'd0;
        if (y_r == 10'(V_TOT - 1)) begin
          y_next_s = 10'd0;
        end else begin
          y_next_s = y_r + 10'd1;
        end
      end else begin
        x_next_s = x_r + 10'd1;
        y_next_s = y_r;
      end
    end else begin
      div_next_s = div_r + DIV_W'(1);
    end
  end

  // State registers; sync/blank flags use next-state x/y for zero latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r      <= {DIV_W{1'b0}};
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      hsync_n_r  <= 1'b1;
      vsync_n_r  <= 1'b1;
      video_on_r <= 1'b0;
    end else begin
      div_r      <= div_next_s;
      x_r        <= x_next_s;
      y_r        <= y_next_s;
      hsync_n_r  <= ~in_hsync(x_next_s);
      vsync_n_r  <= ~in_vsync(y_next_s);
      video_on_r <= in_visible(x_next_s, y_next_s);
    end
  end

  assign vga.x        = x_r;
  assign vga.y        = y_r;
  assign vga.hsync_n  = hsync_n_r;
  assign vga.vsync_n  = vsync_n_r;
  assign vga.video_on = video_on_r;
  // Strobes are gated by rst_n so they stay low for the whole reset period,
  // even with CLK_DIV=1 where the divider already sits at its terminal value.
  assign vga.p_tick      = rst_n & tick_s;
  assign vga.frame_start = rst_n & tick_s & (x_r == 10'd0) & (y_r == 10'd0);

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per pixel, legal range 1..16.
REQ-002 SHALL have parameter H_VIS, default 640: visible pixels per line.
REQ-003 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameter V_VIS, default 480: visible lines per frame.
REQ-005 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical porch and sync widths in lines.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port x, output, 10 bits: current pixel column, feeding the indicator group's x input.
REQ-009 SHALL have port y, output, 10 bits: current line, feeding the indicator group's y input.
REQ-010 SHALL have port hsync_n, output, 1 bit: horizontal sync, active-low.
REQ-011 SHALL have port vsync_n, output, 1 bit: vertical sync, active-low.
REQ-012 SHALL have port video_on, output, 1 bit: high while (x,y) is in the visible area.
REQ-013 SHALL have port p_tick, output, 1 bit: pixel-enable strobe.
REQ-014 SHALL have port frame_start, output, 1 bit: one-clock pulse at the start of each frame.

Function
REQ-015 SHALL hold a divider counter div that counts 0..CLK_DIV-1, advances every clock and wraps to 0.
REQ-016 SHALL drive p_tick = (div == CLK_DIV-1); with CLK_DIV=1, p_tick SHALL be constantly high outside reset.
REQ-017 SHALL change x only on an edge where p_tick is high.
REQ-018 On such an edge, x SHALL increment, and wrap H_TOT-1 -> 0 where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800).
REQ-019 SHALL increment y on the same edge that x wraps, and wrap y V_TOT-1 -> 0 where V_TOT = V_VIS+V_FP+V_SYNC+V_BP (default 525).
REQ-020 SHALL hold x and y unchanged on edges where p_tick is low.
REQ-021 SHALL drive hsync_n low iff H_VIS+H_FP <= x <= H_VIS+H_FP+H_SYNC-1 (default 656..751).
REQ-022 SHALL drive vsync_n low iff V_VIS+V_FP <= y <= V_VIS+V_FP+V_SYNC-1 (default 490..491).
REQ-023 SHALL drive video_on high iff x < H_VIS and y < V_VIS.
REQ-024 hsync_n, vsync_n and video_on SHALL be registered, computed from the next-state x/y, so that in every cycle they match the x/y values presented in that same cycle (zero relative latency, glitch-free).
REQ-025 SHALL pulse frame_start high for exactly one clock: the clock in which x=0, y=0 and p_tick is high.
REQ-026 SHALL never present x >= H_TOT or y >= V_TOT.

Reset
REQ-027 While rst_n is low at a rising edge, SHALL load div=0, x=0, y=0, hsync_n=1, vsync_n=1 and video_on=0.
REQ-028 While rst_n is low, p_tick and frame_start SHALL be 0.
REQ-029 From the first edge with rst_n high, video_on SHALL follow REQ-023; the first x increment SHALL occur CLK_DIV edges after reset release.
REQ-030 rst_n asserted mid-frame SHALL abandon the frame, returning all state to reset values on that edge with no partial sync pulse afterward.

Verification
REQ-031 Reset release, CLK_DIV=4: p_tick high every 4th clock; x steps 0,1,2 at clocks 4,8,12; frame_start high in clock 3 only.
REQ-032 Horizontal line check: hsync_n low for exactly 96 p_ticks (x=656..751); video_on high for x=0..639; x wraps 799->0 and y increments by 1.
REQ-033 Vertical frame check: vsync_n low for exactly 2 lines (y=490,491), i.e. 1600 p_ticks; y wraps 524->0.
REQ-034 Frame period: consecutive frame_start pulses exactly 800*525*4 = 1,680,000 clocks apart; x<800 and y<525 always.
REQ-035 Reset mid-frame: assert rst_n low at x=700, y=491 (both syncs low); the next edge gives x=0, y=0, hsync_n=1, vsync_n=1, video_on=0.
REQ-036 CLK_DIV=1 build: p_tick constantly high after reset; x increments every clock; frame period 420,000 clocks.
